// File: rtl/pipe_ctrl_if.sv
// Handshake/control bundle between the pipeline datapath (master) and pipe_ctrl (slave).
// Carries hazard inputs from D/E/M and the stage-register enables/clears back.
interface pipe_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  ex_wba;
  logic        ex_is_load;
  logic        ex_div_start;
  logic        ibus_busy;
  logic        dbus_busy;
  logic        exc_req;
  logic [31:0] exc_target;

  logic        en_F;
  logic        en_D;
  logic        en_E;
  logic        en_M;
  logic        en_W;
  logic        clear_E;
  logic        clear_M;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        div_busy;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_wba, ex_is_load,
           ex_div_start, ibus_busy, dbus_busy, exc_req, exc_target,
    input  en_F, en_D, en_E, en_M, en_W, clear_E, clear_M, flush,
           redirect_valid, redirect_pc, div_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_wba, ex_is_load,
           ex_div_start, ibus_busy, dbus_busy, exc_req, exc_target,
    output en_F, en_D, en_E, en_M, en_W, clear_E, clear_M, flush,
           redirect_valid, redirect_pc, div_busy
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: load-use bubbles, AXI freeze, divide hold and deferred exception flush.
// Outputs are combinational from state and inputs. STALL_CNT_EN adds stall/flush counters.
module pipe_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   pif
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]  stall_cnt,
  output logic [15:0]  flush_cnt
`endif
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_DIV_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   target_q, target_d;

  // Enables packed as {F, D, E, M, W}.
  logic [4:0] en;
  logic       clear_e;
  logic       clear_m;
  logic       flush;
  logic       redirect_valid;
  logic       div_busy;
  logic       bus_busy;
  logic       load_use;

  assign bus_busy = pif.ibus_busy | pif.dbus_busy;
  assign load_use = pif.ex_is_load && (pif.ex_wba != 5'd0) &&
                    ((pif.id_uses_rs && (pif.id_rs == pif.ex_wba)) ||
                     (pif.id_uses_rt && (pif.id_rt == pif.ex_wba)));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    target_d       = target_q;
    en             = 5'b11111;
    clear_e        = 1'b0;
    clear_m        = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    div_busy       = 1'b0;

    case (state_q)
      S_RUN: begin
        if (pif.exc_req) begin
          en       = 5'b00000;
          target_d = pif.exc_target;
          state_d  = bus_busy ? S_DRAIN : S_FLUSH;
        end else if (bus_busy) begin
          en = 5'b00000;
        end else if (pif.ex_div_start) begin
          // The start cycle is the first of the DIV_CYCLES hold cycles.
          en       = 5'b00011;
          clear_m  = 1'b1;
          div_busy = 1'b1;
          cnt_d    = DIV_LOAD;
          state_d  = S_DIV_WAIT;
        end else if (load_use) begin
          en      = 5'b00111;
          clear_e = 1'b1;
        end
      end

      S_DIV_WAIT: begin
        if (pif.exc_req) begin
          // An older instruction in M faulted: the divide result is discarded.
          en       = 5'b00000;
          cnt_d    = '0;
          target_d = pif.exc_target;
          state_d  = bus_busy ? S_DRAIN : S_FLUSH;
        end else begin
          div_busy = 1'b1;
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_RUN;
          end
          if (bus_busy) begin
            en = 5'b00000;
          end else begin
            en      = 5'b00011;
            clear_m = 1'b1;
          end
        end
      end

      S_DRAIN: begin
        // AXI transfers cannot be cancelled; later exceptions lose to the pending one.
        en = 5'b00000;
        if (!bus_busy) begin
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        state_d        = S_RUN;
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  assign pif.en_F           = en[4];
  assign pif.en_D           = en[3];
  assign pif.en_E           = en[2];
  assign pif.en_M           = en[1];
  assign pif.en_W           = en[0];
  assign pif.clear_E        = clear_e;
  assign pif.clear_M        = clear_m;
  assign pif.flush          = flush;
  assign pif.redirect_valid = redirect_valid;
  assign pif.redirect_pc    = target_q;
  assign pif.div_busy       = div_busy;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!en[4]) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
